dht11_responder: RTL and testbench
==================================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CLK_PER_US, default 50, sets clock cycles per microsecond (50 MHz clock).
REQ-002 Parameter START_MIN_US, default 18000, sets the minimum host low time (us) accepted as a start request.
REQ-003 Parameters RESP_DELAY_US=30, ACK_LOW_US=80, ACK_HIGH_US=80, BIT_LOW_US=50, ZERO_HIGH_US=26, ONE_HIGH_US=70 and END_LOW_US=50 set the response timing, in us.
REQ-004 clock  input  1  system clock, rising edge active.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 read  input  1  sampled level of the shared single-wire data line (TriState read output).
REQ-007 dir  output  1  line drive enable to TriState: 1 = drive `send` onto the line, 0 = release (Z).
REQ-008 send  output  1  level driven on the line while dir=1.
REQ-009 hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to report.
REQ-010 busy  output  1  high from start-request acceptance until the line is released.
REQ-011 done  output  1  single-cycle pulse when a full 40-bit frame completes.

Function
REQ-012 The block SHALL pass `read` through a 2-flop synchronizer; all decisions SHALL use the synchronized level `rd_s`.
REQ-013 The block SHALL contain a microsecond timer that counts cycles to CLK_PER_US and then increments a us counter; the us counter SHALL saturate and never wrap.
REQ-014 The FSM SHALL have exactly the states IDLE, HOST_LOW, RESP_DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-015 IDLE: dir=0; on rd_s=0 go to HOST_LOW and clear the timer.
REQ-016 HOST_LOW: dir=0; on rd_s=1 with elapsed >= START_MIN_US go to RESP_DELAY; on rd_s=1 with elapsed < START_MIN_US (glitch) return to IDLE with no output activity.
REQ-017 When entering RESP_DELAY, the block SHALL latch the four data bytes and the checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256 into a 40-bit shift register and assert busy.
REQ-018 RESP_DELAY: dir=0 for RESP_DELAY_US, then go to ACK_LOW.
REQ-019 ACK_LOW: dir=1, send=0 for ACK_LOW_US. ACK_HIGH: dir=1, send=1 for ACK_HIGH_US.
REQ-020 Frame order SHALL be hum_int, hum_dec, temp_int, temp_dec, checksum, with each byte sent MSB first.
REQ-021 Each bit SHALL be BIT_LOW (dir=1, send=0, BIT_LOW_US) followed by BIT_HIGH (dir=1, send=1, ZERO_HIGH_US for 0, ONE_HIGH_US for 1).
REQ-022 A 6-bit bit counter SHALL select BIT_LOW after each BIT_HIGH while fewer than 40 bits are sent, and END_LOW after the 40th bit.
REQ-023 END_LOW: dir=1, send=0 for END_LOW_US; then dir=0, done=1 for one cycle, busy=0, go to IDLE.
REQ-024 Every phase SHALL last its programmed duration x CLK_PER_US cycles, within +/-1 cycle.
REQ-025 Data input changes during busy SHALL NOT alter the frame in flight.
REQ-026 While busy, the block SHALL ignore the line level and SHALL NOT restart on host activity.
REQ-027 A host low held indefinitely SHALL keep the FSM in HOST_LOW with dir=0.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL set state=IDLE, dir=0, send=1, busy=0, done=0, and clear the timer, bit counter and shift register.
REQ-029 Reset asserted mid-frame SHALL release the line (dir=0) on the next rising edge.

Structure
REQ-030 Package dht11_pkg SHALL hold the FSM state typedef, the default timing constants and the frame length constant (40).
REQ-031 The microsecond timer SHALL be a sub-module named us_timer (inputs clear/enable; output elapsed_us).
REQ-032 The design SHALL connect to the line only through the existing TriState block via dir/send/read.

Verification
REQ-033 Nominal frame: with CLK_PER_US=1 and START_MIN_US=100, the bench holds the host low for 120 us with data 0x37,0x00,0x19,0x00. The bench SHALL decode bytes 0x37,0x00,0x19,0x00,0x50, see one done pulse, and see busy low afterwards.
REQ-034 Glitch rejection: a host low of 60 us SHALL produce dir=0 throughout, no busy assertion and no done pulse.
REQ-035 Checksum wrap: data 0xFF,0xFF,0xFF,0x03 SHALL produce checksum 0x00.
REQ-036 Timing check: for data 0x80,0x00,0x00,0x00, the first bit SHALL have a 70-cycle high phase and the second bit a 26-cycle high phase; ACK_LOW and ACK_HIGH SHALL each last 80 cycles.
REQ-037 Reset mid-frame: reset=0 during bit 12 SHALL give dir=0 one edge later. A following valid start request SHALL produce a complete, correct frame.
REQ-038 Data change during busy: changing temp_int from 0x19 to 0x20 at bit 5 SHALL still transmit 0x19 and checksum 0x50.

Source files
------------

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared states, timing defaults and helpers for the DHT11 responder
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_DELAY,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_e;

    localparam int unsigned DEF_CLK_PER_US   = 50;
    localparam int unsigned DEF_START_MIN_US = 18000;
    localparam int unsigned DEF_RESP_DELAY_US = 30;
    localparam int unsigned DEF_ACK_LOW_US   = 80;
    localparam int unsigned DEF_ACK_HIGH_US  = 80;
    localparam int unsigned DEF_BIT_LOW_US   = 50;
    localparam int unsigned DEF_ZERO_HIGH_US = 26;
    localparam int unsigned DEF_ONE_HIGH_US  = 70;
    localparam int unsigned DEF_END_LOW_US   = 50;

    localparam int unsigned FRAME_BITS = 40;
    localparam int          US_W       = 16;

    // True on the last cycle of a phase of dur microseconds: the microsecond
    // currently in progress is the one that completes the duration.
    function automatic logic phase_end(input logic [US_W-1:0] elapsed,
                                       input logic            tick,
                                       input logic [US_W-1:0] dur);
        return tick && (({1'b0, elapsed} + 17'd1) >= {1'b0, dur});
    endfunction

    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_responder_us_timer.sv
// rtl/dht11_responder_us_timer.sv - cycle prescaler plus saturating microsecond counter
module us_timer
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [US_W-1:0] elapsed_us,
    output logic            tick
);

    localparam logic [15:0] CYC_LAST = 16'(CLK_PER_US - 1);

    logic [15:0]     cyc_q, cyc_d;
    logic [US_W-1:0] us_q, us_d;

    assign tick       = enable && (cyc_q == CYC_LAST);
    assign elapsed_us = us_q;

    always_comb begin
        cyc_d = cyc_q;
        us_d  = us_q;
        if (clear) begin
            cyc_d = '0;
            us_d  = '0;
        end else if (enable) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (us_q != '1) begin
                    us_d = us_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q <= '0;
            us_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            us_q  <= us_d;
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor-side responder driving the single-wire line via dir/send
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = DEF_CLK_PER_US,
    parameter int unsigned START_MIN_US  = DEF_START_MIN_US,
    parameter int unsigned RESP_DELAY_US = DEF_RESP_DELAY_US,
    parameter int unsigned ACK_LOW_US    = DEF_ACK_LOW_US,
    parameter int unsigned ACK_HIGH_US   = DEF_ACK_HIGH_US,
    parameter int unsigned BIT_LOW_US    = DEF_BIT_LOW_US,
    parameter int unsigned ZERO_HIGH_US  = DEF_ZERO_HIGH_US,
    parameter int unsigned ONE_HIGH_US   = DEF_ONE_HIGH_US,
    parameter int unsigned END_LOW_US    = DEF_END_LOW_US
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    output logic       dir,
    output logic       send,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       done
);

    localparam logic [US_W-1:0] START_US  = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] RESP_US   = US_W'(RESP_DELAY_US);
    localparam logic [US_W-1:0] ACKL_US   = US_W'(ACK_LOW_US);
    localparam logic [US_W-1:0] ACKH_US   = US_W'(ACK_HIGH_US);
    localparam logic [US_W-1:0] BITL_US   = US_W'(BIT_LOW_US);
    localparam logic [US_W-1:0] ZERO_US   = US_W'(ZERO_HIGH_US);
    localparam logic [US_W-1:0] ONE_US    = US_W'(ONE_HIGH_US);
    localparam logic [US_W-1:0] ENDL_US   = US_W'(END_LOW_US);
    localparam logic [5:0]      LAST_BIT  = 6'(FRAME_BITS - 1);

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [39:0]     shift_q, shift_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic            dir_q, dir_d;
    logic            send_q, send_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timer_clear;
    logic            timer_en;
    logic            tick;
    logic            rd_s;
    logic [US_W-1:0] elapsed_us;

    assign rd_s     = sync_q[1];
    assign sync_d   = {sync_q[0], read};
    assign timer_en = (state_q != IDLE);

    us_timer #(
        .CLK_PER_US(CLK_PER_US)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (timer_clear),
        .enable    (timer_en),
        .elapsed_us(elapsed_us),
        .tick      (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        timer_clear = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rd_s) begin
                    state_d     = HOST_LOW;
                    timer_clear = 1'b1;
                end
            end
            HOST_LOW: begin
                if (rd_s) begin
                    timer_clear = 1'b1;
                    if (elapsed_us >= START_US) begin
                        state_d   = RESP_DELAY;
                        shift_d   = {hum_int, hum_dec, temp_int, temp_dec,
                                     checksum(hum_int, hum_dec, temp_int, temp_dec)};
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP_DELAY: begin
                if (phase_end(elapsed_us, tick, RESP_US)) begin
                    state_d     = ACK_LOW;
                    timer_clear = 1'b1;
                end
            end
            ACK_LOW: begin
                if (phase_end(elapsed_us, tick, ACKL_US)) begin
                    state_d     = ACK_HIGH;
                    timer_clear = 1'b1;
                end
            end
            ACK_HIGH: begin
                if (phase_end(elapsed_us, tick, ACKH_US)) begin
                    state_d     = BIT_LOW;
                    timer_clear = 1'b1;
                end
            end
            BIT_LOW: begin
                if (phase_end(elapsed_us, tick, BITL_US)) begin
                    state_d     = BIT_HIGH;
                    timer_clear = 1'b1;
                end
            end
            BIT_HIGH: begin
                // The bit on the wire is always the MSB of the shift register.
                if (phase_end(elapsed_us, tick, shift_q[39] ? ONE_US : ZERO_US)) begin
                    timer_clear = 1'b1;
                    shift_d     = {shift_q[38:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 6'd1;
                    state_d     = (bit_cnt_q == LAST_BIT) ? END_LOW : BIT_LOW;
                end
            end
            END_LOW: begin
                if (phase_end(elapsed_us, tick, ENDL_US)) begin
                    state_d     = IDLE;
                    timer_clear = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dir_d  = state_d inside {ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW};
        send_d = !(state_d inside {ACK_LOW, BIT_LOW, END_LOW});
        busy_d = !(state_d inside {IDLE, HOST_LOW});
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dir_q     <= 1'b0;
            send_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            send_q    <= send_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dir  = dir_q;
    assign send = send_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - host-side bench decoding DHT11 frames against a waveform model
module tb_dht11_responder;

    localparam int START_US = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       host_level = 1'b1;
    logic       read;
    logic       dir, send, busy, done;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;

    always #5 clock = ~clock;

    // Open-drain style line: the sensor drives when dir=1, otherwise the host (or pull-up).
    assign read = dir ? send : host_level;

    dht11_responder #(
        .CLK_PER_US  (1),
        .START_MIN_US(START_US)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .read    (read),
        .dir     (dir),
        .send    (send),
        .hum_int (hum_int),
        .hum_dec (hum_dec),
        .temp_int(temp_int),
        .temp_dec(temp_dec),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        string      name;
        logic [7:0] hi, hd, ti, td;
        int         low_us;
        bit         acc;
        logic [7:0] cs;
        int         chg_bit;
        int         rst_bit;
    } vec_t;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int lv[$];
    int ln[$];

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] model_cs(input int a, input int b, input int c, input int d);
        return 8'((a + b + c + d) % 256);
    endfunction

    task automatic run_frame(input vec_t v);
        logic [7:0] fb[5];
        int  exp_lv[$];
        int  exp_ln[$];
        int  cur_l = 0, cur_n = 0, dones = 0, post = -1, bad = -1, budget;
        bit  dir_hl = 0, dir_seen = 0, busy_seen = 0, busy_end = 1, ended = 0, aborted = 0;
        lv.delete();
        ln.delete();
        hum_int = v.hi; hum_dec = v.hd; temp_int = v.ti; temp_dec = v.td;
        fb = '{v.hi, v.hd, v.ti, v.td, v.cs};
        exp_lv = '{0, 1};
        exp_ln = '{80, 80};
        for (int k = 0; k < 40; k++) begin
            exp_lv.push_back(0); exp_ln.push_back(50);
            exp_lv.push_back(1); exp_ln.push_back(fb[k / 8][7 - (k % 8)] ? 70 : 26);
        end
        exp_lv.push_back(0); exp_ln.push_back(50);

        host_level = 1'b0;
        repeat (v.low_us) begin
            @(negedge clock);
            if (dir || busy) dir_hl = 1;
        end
        host_level = 1'b1;

        budget = v.acc ? 7000 : 300;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (done) dones++;
            if (busy) busy_seen = 1;
            if (dir) begin
                dir_seen = 1;
                if (cur_n > 0 && cur_l == int'(send)) cur_n++;
                else begin
                    if (cur_n > 0) begin lv.push_back(cur_l); ln.push_back(cur_n); end
                    cur_l = int'(send);
                    cur_n = 1;
                end
                if (v.chg_bit >= 0 && lv.size() == 2 + 2 * v.chg_bit && cur_n == 1)
                    temp_int = 8'h20;
                if (v.rst_bit >= 0 && lv.size() == 2 + 2 * v.rst_bit && cur_n == 5) begin
                    reset = 1'b0;
                    @(negedge clock);
                    chk({v.name, ".reset_dir"}, int'(dir), 0);
                    chk({v.name, ".reset_busy"}, int'(busy), 0);
                    reset = 1'b1;
                    aborted = 1;
                    break;
                end
            end else if (cur_n > 0) begin
                lv.push_back(cur_l); ln.push_back(cur_n);
                cur_n = 0; busy_end = busy; ended = 1; post = 0;
            end
            if (post >= 0) begin
                post++;
                if (post > 3) break;
            end
        end

        chk({v.name, ".host_low_quiet"}, int'(dir_hl), 0);
        if (aborted) return;
        if (!v.acc) begin
            chk({v.name, ".dir_seen"}, int'(dir_seen), 0);
            chk({v.name, ".busy_seen"}, int'(busy_seen), 0);
            chk({v.name, ".done_count"}, dones, 0);
            return;
        end
        chk({v.name, ".frame_end"}, int'(ended), 1);
        chk({v.name, ".seg_count"}, lv.size(), exp_lv.size());
        for (int i = 0; i < lv.size() && i < exp_lv.size(); i++) begin
            if (bad < 0 && (lv[i] != exp_lv[i] || ln[i] > exp_ln[i] + 1 || ln[i] < exp_ln[i] - 1))
                bad = i;
        end
        chk({v.name, ".first_bad_segment"}, bad, -1);
        for (int b = 0; b < 5; b++) begin
            logic [7:0] got = 8'h00;
            for (int k = 0; k < 8; k++) begin
                int idx = 3 + 2 * (b * 8 + k);
                got = {got[6:0], (idx < ln.size()) ? (ln[idx] > 48) : 1'b0};
            end
            chk($sformatf("%s.byte%0d", v.name, b), int'(got), int'(fb[b]));
        end
        chk({v.name, ".done_count"}, dones, 1);
        chk({v.name, ".busy_seen"}, int'(busy_seen), 1);
        chk({v.name, ".busy_after"}, int'(busy_end), 0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{"nominal",  8'h37, 8'h00, 8'h19, 8'h00, 120,  1'b1, 8'h50, -1, -1});
        tbl.push_back('{"glitch",   8'h37, 8'h00, 8'h19, 8'h00, 60,   1'b0, 8'h50, -1, -1});
        tbl.push_back('{"cs_wrap",  8'hFF, 8'hFF, 8'hFF, 8'h03, 120,  1'b1, 8'h00, -1, -1});
        tbl.push_back('{"timing",   8'h80, 8'h00, 8'h00, 8'h00, 120,  1'b1, 8'h80, -1, -1});
        tbl.push_back('{"long_low", 8'h01, 8'h02, 8'h03, 8'h04, 1000, 1'b1, 8'h0A, -1, -1});
        tbl.push_back('{"data_chg", 8'h37, 8'h00, 8'h19, 8'h00, 120,  1'b1, 8'h50, 5, -1});
        tbl.push_back('{"mid_rst",  8'h12, 8'h34, 8'h56, 8'h78, 120,  1'b1, 8'h14, -1, 12});
        tbl.push_back('{"post_rst", 8'hA5, 8'h5A, 8'h0F, 8'hF0, 120,  1'b1, 8'hFE, -1, -1});
        for (int r = 0; r < 3; r++) begin
            vec_t v;
            v.name = $sformatf("rand%0d", r);
            v.hi = 8'($urandom); v.hd = 8'($urandom); v.ti = 8'($urandom); v.td = 8'($urandom);
            v.low_us = $urandom_range(40, 220);
            if (v.low_us >= START_US - 10 && v.low_us < START_US + 10) v.low_us = START_US + 30;
            v.acc = (v.low_us >= START_US);
            v.cs = model_cs(v.hi, v.hd, v.ti, v.td);
            v.chg_bit = -1;
            v.rst_bit = -1;
            tbl.push_back(v);
        end

        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("reset.dir", int'(dir), 0);
        chk("reset.send", int'(send), 1);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        foreach (tbl[i]) begin
            run_frame(tbl[i]);
            if (tbl[i].name == "timing" && ln.size() > 5) begin
                chk("timing.ack_low", ln[0], 80);
                chk("timing.ack_high", ln[1], 80);
                chk("timing.bit0_high", ln[3], 70);
                chk("timing.bit1_high", ln[5], 26);
            end
            repeat (50) @(negedge clock);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
